// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pkg
// Brief    : Shared constants, drain FSM encoding and index-width helper for the
//            systolic MAC array and its result unloader.
// Revision : 1.0
// ============================================================================
package systolic_pkg;

  localparam int unsigned c_data_width_def = 32;
  localparam int unsigned c_n_def          = 3;
  localparam int unsigned c_m_def          = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } drain_state_t;

  // Counter width for an index over n positions; a single position still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned c_row_w_def = idx_width(c_n_def);
  localparam int unsigned c_col_w_def = idx_width(c_m_def);

endpackage
`default_nettype wire

// File: rtl/result_snapshot.sv
`default_nettype none
// ============================================================================
// Module   : result_snapshot
// Brief    : N x M accumulator snapshot bank with capture enable and row/col read.
// Revision : 1.0
// ============================================================================
module result_snapshot
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = c_data_width_def,
  parameter int unsigned N          = c_n_def,
  parameter int unsigned M          = c_m_def
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_capture,
  input  logic [N*M*DATA_WIDTH-1:0]    i_c_flat,
  input  logic [idx_width(N)-1:0]      i_rd_row,
  input  logic [idx_width(M)-1:0]      i_rd_col,
  output logic [DATA_WIDTH-1:0]        o_rd_data
);

  logic [DATA_WIDTH-1:0] w_bank [N][M];

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < M; gj++) begin : g_col
        logic [DATA_WIDTH-1:0] r_elem;

        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            r_elem <= '0;
          end else if (i_capture) begin
            r_elem <= i_c_flat[(gi*M+gj)*DATA_WIDTH +: DATA_WIDTH];
          end
        end

        assign w_bank[gi][gj] = r_elem;
      end
    end
  endgenerate

  assign o_rd_data = w_bank[i_rd_row][i_rd_col];

endmodule
`default_nettype wire

// File: rtl/systolic_drain.sv
`default_nettype none
// ============================================================================
// Module   : systolic_drain
// Brief    : Snapshots the MAC array results on load and streams them out
//            row-major over valid/ready, pulsing finished after the last one.
// Revision : 1.0
// ============================================================================
module systolic_drain
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = c_data_width_def,
  parameter int unsigned N          = c_n_def,
  parameter int unsigned M          = c_m_def
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [N*M*DATA_WIDTH-1:0]    C_flat,
  input  logic                         res_ready,
  output logic                         res_valid,
  output logic [DATA_WIDTH-1:0]        res_data,
  output logic [idx_width(N)-1:0]      res_row,
  output logic [idx_width(M)-1:0]      res_col,
  output logic                         res_last,
  output logic                         finished,
  output logic                         busy,
  output logic                         overflow
);

  localparam int unsigned c_row_w = idx_width(N);
  localparam int unsigned c_col_w = idx_width(M);
  localparam logic [c_row_w-1:0] c_last_row = c_row_w'(N-1);
  localparam logic [c_col_w-1:0] c_last_col = c_col_w'(M-1);

  drain_state_t           r_state;
  drain_state_t           w_state_nxt;
  logic [c_row_w-1:0]     r_row;
  logic [c_col_w-1:0]     r_col;
  logic                   r_overflow;
  logic                   w_capture;
  logic                   w_handshake;
  logic                   w_at_last;
  logic [DATA_WIDTH-1:0]  w_snap_data;

  result_snapshot #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (N),
    .M          (M)
  ) u_snapshot (
    .clk        (clk),
    .rst        (rst),
    .i_capture  (w_capture),
    .i_c_flat   (C_flat),
    .i_rd_row   (r_row),
    .i_rd_col   (r_col),
    .o_rd_data  (w_snap_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (load) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_handshake && w_at_last) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_capture = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b0;
    finished  = 1'b0;
    case (r_state)
      ST_IDLE:  w_capture = load;
      ST_DRAIN: begin
        res_valid = 1'b1;
        busy      = 1'b1;
      end
      ST_DONE:  begin
        busy     = 1'b1;
        finished = 1'b1;
      end
      default:  ;
    endcase
  end

  assign w_handshake = res_valid & res_ready;
  assign w_at_last   = (r_row == c_last_row) && (r_col == c_last_col);

  // Both counters return to zero after the final element so IDLE always shows (0,0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_capture) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_handshake) begin
      if (r_col == c_last_col) begin
        r_col <= '0;
        r_row <= w_at_last ? '0 : r_row + c_row_w'(1);
      end else begin
        r_col <= r_col + c_col_w'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (load && (r_state != ST_IDLE)) begin
      r_overflow <= 1'b1;
    end
  end

  assign res_data = res_valid ? w_snap_data : '0;
  assign res_row  = r_row;
  assign res_col  = r_col;
  assign res_last = res_valid & w_at_last;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_systolic_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_drain
// Brief    : Directed self-checking bench for the systolic result unloader.
// Revision : 1.0
// ============================================================================
module tb_systolic_drain;

  localparam int unsigned c_dw = 32;
  localparam int unsigned c_n  = 3;
  localparam int unsigned c_m  = 3;
  localparam int unsigned c_ne = c_n * c_m;

  logic                     clk;
  logic                     rst;
  logic                     load;
  logic [c_ne*c_dw-1:0]     C_flat;
  logic                     res_ready;
  logic                     res_valid;
  logic [c_dw-1:0]          res_data;
  logic [1:0]               res_row;
  logic [1:0]               res_col;
  logic                     res_last;
  logic                     finished;
  logic                     busy;
  logic                     overflow;

  int n_tests = 0;
  int n_fail  = 0;

  systolic_drain #(
    .DATA_WIDTH (c_dw),
    .N          (c_n),
    .M          (c_m)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .C_flat     (C_flat),
    .res_ready  (res_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_row    (res_row),
    .res_col    (res_col),
    .res_last   (res_last),
    .finished   (finished),
    .busy       (busy),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [c_dw-1:0] elem(input int base, input int i, input int j);
    return c_dw'(base + 10*i + j);
  endfunction

  task automatic set_c(input int base);
    for (int i = 0; i < c_n; i++)
      for (int j = 0; j < c_m; j++)
        C_flat[(i*c_m+j)*c_dw +: c_dw] = elem(base, i, j);
  endtask

  task automatic check_idle(input string tag, input logic exp_ovf);
    check({tag, "_valid"},    64'(res_valid), 64'd0);
    check({tag, "_data"},     64'(res_data),  64'd0);
    check({tag, "_last"},     64'(res_last),  64'd0);
    check({tag, "_finished"}, 64'(finished),  64'd0);
    check({tag, "_busy"},     64'(busy),      64'd0);
    check({tag, "_overflow"}, 64'(overflow),  64'(exp_ovf));
  endtask

  // Pulse load for one cycle; optionally clobber C_flat the cycle after the load edge.
  task automatic pulse_load(input int base, input bit wait_first, input bit clobber);
    if (wait_first) @(negedge clk);
    set_c(base);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    if (clobber) C_flat = '1;
  endtask

  // Called at the negedge where element (0,0) should be presented. Returns at the
  // first IDLE negedge after DONE. inj >= 0 drives a stray load on that cycle.
  task automatic drain_check(input string tag, input int base, input logic [3:0] pat, input int inj);
    int k   = 0;
    int cyc = 0;
    logic rdy;
    while (k < c_ne && cyc < 200) begin
      check($sformatf("%s_valid_%0d", tag, cyc), 64'(res_valid), 64'd1);
      check($sformatf("%s_busy_%0d",  tag, cyc), 64'(busy),      64'd1);
      check($sformatf("%s_data_%0d",  tag, cyc), 64'(res_data),  64'(elem(base, k / c_m, k % c_m)));
      check($sformatf("%s_row_%0d",   tag, cyc), 64'(res_row),   64'(k / c_m));
      check($sformatf("%s_col_%0d",   tag, cyc), 64'(res_col),   64'(k % c_m));
      check($sformatf("%s_last_%0d",  tag, cyc), 64'(res_last),  64'(k == c_ne - 1));
      check($sformatf("%s_fin_%0d",   tag, cyc), 64'(finished),  64'd0);
      rdy = pat[cyc % 4];
      res_ready = rdy;
      if (cyc == inj) begin
        set_c(base + 500);
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (rdy) k++;
    end
    load = 1'b0;
    check({tag, "_no_timeout"}, 64'(cyc < 200), 64'd1);
    check({tag, "_done_fin"},   64'(finished),  64'd1);
    check({tag, "_done_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_done_busy"},  64'(busy),      64'd1);
    @(negedge clk);
    check({tag, "_idle_fin"},   64'(finished),  64'd0);
    check({tag, "_idle_busy"},  64'(busy),      64'd0);
    check({tag, "_idle_valid"}, 64'(res_valid), 64'd0);
  endtask

  initial begin
    rst       = 1'b0;
    load      = 1'b0;
    C_flat    = '0;
    res_ready = 1'b0;
    #1;
    check_idle("reset", 1'b0);
    check("reset_row", 64'(res_row), 64'd0);
    check("reset_col", 64'(res_col), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Ready in IDLE must not start anything.
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_idle("idle_ready", 1'b0);

    pulse_load(0, 1'b0, 1'b0);
    drain_check("basic", 0, 4'b1111, -1);

    pulse_load(100, 1'b1, 1'b0);
    drain_check("bp", 100, 4'b1001, -1);

    pulse_load(200, 1'b1, 1'b1);
    drain_check("iso", 200, 4'b1111, -1);

    // Load lands in the first IDLE cycle right after the previous DONE.
    pulse_load(300, 1'b0, 1'b0);
    drain_check("b2b", 300, 4'b1111, -1);
    check("b2b_overflow", 64'(overflow), 64'd0);

    pulse_load(400, 1'b1, 1'b0);
    drain_check("ovf", 400, 4'b1111, 2);
    check("ovf_sticky", 64'(overflow), 64'd1);
    @(negedge clk);
    check("ovf_sticky2", 64'(overflow), 64'd1);
    pulse_load(600, 1'b1, 1'b0);
    drain_check("ovf_new", 600, 4'b1111, -1);
    check("ovf_still", 64'(overflow), 64'd1);

    // Reset mid-drain after four handshakes.
    pulse_load(700, 1'b1, 1'b0);
    res_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_data_before", 64'(res_data), 64'(elem(700, 1, 1)));
    rst = 1'b0;
    #1;
    check_idle("mid_rst", 1'b0);
    check("mid_rst_row", 64'(res_row), 64'd0);
    check("mid_rst_col", 64'(res_col), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("mid_rst_nofin_%0d", c), 64'(finished), 64'd0);
    end
    rst = 1'b1;
    pulse_load(800, 1'b1, 1'b0);
    drain_check("fresh", 800, 4'b1111, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
